// File: rtl/qsys_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : qsys_timer_sequencer
//  Description : Avalon-MM master that programs the 16-bit-register interval
//                timer, services its IRQ (status clear + tick pulse), stops
//                it on request and performs atomic 32-bit counter snapshots.
//  Revision    : 1.0 - initial release
// ============================================================================
module qsys_timer_sequencer #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              stop_req,
    input  logic              snap_req,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              running,
    output logic              busy,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_PL   = 4'd1,
        S_WR_PH   = 4'd2,
        S_WR_CTL  = 4'd3,
        S_WR_CLR  = 4'd4,
        S_ACK     = 4'd5,
        S_STP     = 4'd6,
        S_STP_CLR = 4'd7,
        S_SN_WR   = 4'd8,
        S_SN_RDL  = 4'd9,
        S_SN_RDH  = 4'd10,
        S_SN_CAP  = 4'd11
    } state_t;

    localparam logic [TICK_W-1:0] c_tick_one = {{(TICK_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                stop_pend_q, stop_pend_d;
    logic                snap_pend_q, snap_pend_d;
    logic [31:0]         load_q, load_d;
    logic                cont_q, cont_d;
    logic                running_q, running_d;
    logic [TICK_W-1:0]   tick_count_q, tick_count_d;
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         snap_value_q, snap_value_d;

    logic                w_idle;
    logic                w_cfg_fire;
    logic                w_stop_serve;
    logic                w_snap_serve;

    // IDLE arbitration: IRQ beats stop, stop beats config, config beats snapshot
    assign w_idle       = (state_q == S_IDLE);
    assign cfg_ready    = w_idle & ~tmr_irq & ~stop_pend_q & ~reset;
    assign w_cfg_fire   = cfg_valid & cfg_ready;
    assign w_stop_serve = w_idle & ~tmr_irq & stop_pend_q;
    assign w_snap_serve = w_idle & ~tmr_irq & ~stop_pend_q & ~w_cfg_fire & snap_pend_q;

    assign busy       = ~w_idle;
    assign tick       = (state_q == S_ACK);
    assign snap_valid = (state_q == S_SN_CAP);
    assign running    = running_q;
    assign tick_count = tick_count_q;
    // High half arrives on the bus in the capture cycle itself, so present it directly
    assign snap_value = (state_q == S_SN_CAP) ? {tmr_readdata, snap_lo_q} : snap_value_q;

    // Next-state, pending-flag and shadow-register logic
    always_comb begin
        state_d      = state_q;
        stop_pend_d  = w_stop_serve ? 1'b0 : (stop_pend_q | stop_req);
        snap_pend_d  = w_snap_serve ? 1'b0 : (snap_pend_q | snap_req);
        load_d       = load_q;
        cont_d       = cont_q;
        running_d    = running_q;
        tick_count_d = tick_count_q;
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;

        case (state_q)
            S_IDLE: begin
                if (tmr_irq) begin
                    state_d = S_ACK;
                end else if (stop_pend_q) begin
                    state_d = S_STP;
                end else if (w_cfg_fire) begin
                    state_d = S_WR_PL;
                    // A period of 0 behaves as 1, so the load value saturates at 0
                    load_d  = (cfg_period == 32'd0) ? 32'd0 : (cfg_period - 32'd1);
                    cont_d  = cfg_continuous;
                end else if (snap_pend_q) begin
                    state_d = S_SN_WR;
                end
            end
            S_WR_PL:   state_d = S_WR_PH;
            S_WR_PH:   state_d = S_WR_CTL;
            S_WR_CTL: begin
                state_d   = S_WR_CLR;
                running_d = 1'b1;
            end
            S_WR_CLR:  state_d = S_IDLE;
            S_ACK: begin
                state_d      = S_IDLE;
                tick_count_d = tick_count_q + c_tick_one;
                if (!cont_q) begin
                    running_d = 1'b0;
                end
            end
            S_STP: begin
                state_d   = S_STP_CLR;
                running_d = 1'b0;
            end
            S_STP_CLR: state_d = S_IDLE;
            S_SN_WR:   state_d = S_SN_RDL;
            S_SN_RDL:  state_d = S_SN_RDH;
            S_SN_RDH: begin
                state_d   = S_SN_CAP;
                snap_lo_d = tmr_readdata;
            end
            S_SN_CAP: begin
                state_d      = S_IDLE;
                snap_value_d = {tmr_readdata, snap_lo_q};
            end
            default:   state_d = S_IDLE;
        endcase
    end

    // Bus drive decoded from state and registered shadow data only
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'h0000;
        case (state_q)
            S_WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd2;
                tmr_writedata  = load_q[15:0];
            end
            S_WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd3;
                tmr_writedata  = load_q[31:16];
            end
            S_WR_CTL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
            end
            S_WR_CLR, S_ACK, S_STP_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd0;
            end
            S_STP: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd1;
                tmr_writedata  = 16'h0008;
            end
            S_SN_WR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = 3'd4;
            end
            S_SN_RDL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd4;
            end
            S_SN_RDH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = 3'd5;
            end
            default: begin
                tmr_chipselect = 1'b0;
            end
        endcase
    end

    // State and shadow registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            load_q       <= 32'd0;
            cont_q       <= 1'b0;
            running_q    <= 1'b0;
            tick_count_q <= '0;
            snap_lo_q    <= 16'h0000;
            snap_value_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            load_q       <= load_d;
            cont_q       <= cont_d;
            running_q    <= running_d;
            tick_count_q <= tick_count_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qsys_timer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qsys_timer_sequencer
//  Description : Directed self-checking bench for qsys_timer_sequencer; the
//                bench plays the timer (irq and readdata) by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qsys_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_period;
    logic        cfg_continuous;
    logic        stop_req;
    logic        snap_req;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic        tick;
    logic [15:0] tick_count;
    logic        running;
    logic        busy;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    int total = 0;
    int bad   = 0;
    int extra_ticks;

    qsys_timer_sequencer #(.TICK_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_period     (cfg_period),
        .cfg_continuous (cfg_continuous),
        .stop_req       (stop_req),
        .snap_req       (snap_req),
        .snap_valid     (snap_valid),
        .snap_value     (snap_value),
        .tick           (tick),
        .tick_count     (tick_count),
        .running        (running),
        .busy           (busy),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    // Bus snapshot packed as {chipselect, write_n, address, writedata}
    logic [20:0] bus_obs;
    assign bus_obs = {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};

    function automatic logic [20:0] b_idle();
        return {1'b0, 1'b1, 3'd0, 16'h0000};
    endfunction

    function automatic logic [20:0] b_wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    function automatic logic [20:0] b_rd(input logic [2:0] a);
        return {1'b1, 1'b1, a, 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        cfg_valid      = 1'b0;
        cfg_period     = 32'd0;
        cfg_continuous = 1'b0;
        stop_req       = 1'b0;
        snap_req       = 1'b0;
        tmr_readdata   = 16'h0000;
        tmr_irq        = 1'b0;

        // ---- reset state
        cyc(); cyc(); settle();
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_tick",       {31'd0, tick},       32'd0);
        chk("rst_tick_count", {16'd0, tick_count}, 32'd0);
        chk("rst_running",    {31'd0, running},    32'd0);
        chk("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
        chk("rst_snap_value", snap_value,          32'd0);
        chk("rst_bus",        {11'd0, bus_obs},    {11'd0, b_idle()});
        chk("rst_cfg_ready",  {31'd0, cfg_ready},  32'd0);
        reset = 1'b0;
        settle();
        chk("rst_release_ready", {31'd0, cfg_ready}, 32'd1);

        // ---- continuous config, period 10 -> L = 9, control 0x0007
        cycle_cfg: begin
            cfg_valid = 1'b1; cfg_period = 32'd10; cfg_continuous = 1'b1;
            settle();
            chk("cont_ready", {31'd0, cfg_ready}, 32'd1);
            cyc(); cfg_valid = 1'b0; settle();
            chk("cont_wr_pl",  {11'd0, bus_obs}, {11'd0, b_wr(3'd2, 16'h0009)});
            chk("cont_busy",   {31'd0, busy},    32'd1);
            cyc(); settle();
            chk("cont_wr_ph",  {11'd0, bus_obs}, {11'd0, b_wr(3'd3, 16'h0000)});
            cyc(); settle();
            chk("cont_wr_ctl", {11'd0, bus_obs}, {11'd0, b_wr(3'd1, 16'h0007)});
            chk("cont_run_pre", {31'd0, running}, 32'd0);
            cyc(); settle();
            chk("cont_wr_clr", {11'd0, bus_obs}, {11'd0, b_wr(3'd0, 16'h0000)});
            chk("cont_running", {31'd0, running}, 32'd1);
            cyc(); settle();
            chk("cont_idle_ready", {31'd0, cfg_ready}, 32'd1);
            chk("cont_idle_bus", {11'd0, bus_obs}, {11'd0, b_idle()});
        end

        // ---- five timeouts, one every 10 clocks
        for (int k = 1; k <= 5; k++) begin
            repeat (8) cyc();
            tmr_irq = 1'b1; settle();
            chk("irq_blocks_ready", {31'd0, cfg_ready}, 32'd0);
            cyc(); tmr_irq = 1'b0; settle();
            chk("ack_tick", {31'd0, tick}, 32'd1);
            chk("ack_bus",  {11'd0, bus_obs}, {11'd0, b_wr(3'd0, 16'h0000)});
            cyc(); settle();
            chk("ack_tick_end", {31'd0, tick}, 32'd0);
            chk("ack_count", {16'd0, tick_count}, k);
        end
        chk("cont_still_running", {31'd0, running}, 32'd1);

        // ---- stop while running; two merged requests give one service
        stop_req = 1'b1; cyc(); stop_req = 1'b0; settle();
        chk("stop_pend_idle", {31'd0, busy}, 32'd0);
        chk("stop_pend_ready", {31'd0, cfg_ready}, 32'd0);
        stop_req = 1'b1;
        cyc(); stop_req = 1'b0; settle();
        chk("stp_bus", {11'd0, bus_obs}, {11'd0, b_wr(3'd1, 16'h0008)});
        cyc(); settle();
        chk("stp_clr_bus", {11'd0, bus_obs}, {11'd0, b_wr(3'd0, 16'h0000)});
        chk("stp_running", {31'd0, running}, 32'd0);
        cyc(); settle();
        chk("stp_done_idle", {31'd0, busy}, 32'd0);
        cyc(); settle();
        chk("stp_merged_idle", {31'd0, busy}, 32'd0);
        chk("stp_count_frozen", {16'd0, tick_count}, 32'd5);

        // ---- one-shot, period 0 -> L = 0, control 0x0005
        cfg_valid = 1'b1; cfg_period = 32'd0; cfg_continuous = 1'b0;
        cyc(); cfg_valid = 1'b0; settle();
        chk("os_wr_pl", {11'd0, bus_obs}, {11'd0, b_wr(3'd2, 16'h0000)});
        cyc(); settle();
        chk("os_wr_ph", {11'd0, bus_obs}, {11'd0, b_wr(3'd3, 16'h0000)});
        cyc(); settle();
        chk("os_wr_ctl", {11'd0, bus_obs}, {11'd0, b_wr(3'd1, 16'h0005)});
        cyc(); cyc(); settle();
        chk("os_running", {31'd0, running}, 32'd1);
        tmr_irq = 1'b1;
        cyc(); tmr_irq = 1'b0; settle();
        chk("os_tick", {31'd0, tick}, 32'd1);
        cyc(); settle();
        chk("os_stopped", {31'd0, running}, 32'd0);
        chk("os_count", {16'd0, tick_count}, 32'd6);
        extra_ticks = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (tick) extra_ticks++;
        end
        chk("os_no_more_ticks", extra_ticks, 32'd0);

        // ---- snapshot of 0x0001_2345
        snap_req = 1'b1; cyc(); snap_req = 1'b0; settle();
        chk("sn_pend_idle", {31'd0, busy}, 32'd0);
        cyc(); settle();
        chk("sn_wr_bus", {11'd0, bus_obs}, {11'd0, b_wr(3'd4, 16'h0000)});
        cyc(); tmr_readdata = 16'hDEAD; settle();
        chk("sn_rdl_bus", {11'd0, bus_obs}, {11'd0, b_rd(3'd4)});
        chk("sn_rdl_valid", {31'd0, snap_valid}, 32'd0);
        cyc(); tmr_readdata = 16'h2345; settle();
        chk("sn_rdh_bus", {11'd0, bus_obs}, {11'd0, b_rd(3'd5)});
        cyc(); tmr_readdata = 16'h0001; settle();
        chk("sn_cap_valid", {31'd0, snap_valid}, 32'd1);
        chk("sn_cap_value", snap_value, 32'h0001_2345);
        chk("sn_cap_bus", {11'd0, bus_obs}, {11'd0, b_idle()});
        cyc(); tmr_readdata = 16'hBEEF; settle();
        chk("sn_valid_end", {31'd0, snap_valid}, 32'd0);
        chk("sn_value_hold", snap_value, 32'h0001_2345);
        chk("sn_back_idle", {31'd0, busy}, 32'd0);

        // ---- irq, stop and cfg together: ACK, then STP, then config
        cfg_valid = 1'b1; cfg_period = 32'd3; cfg_continuous = 1'b0;
        stop_req = 1'b1; tmr_irq = 1'b1; settle();
        chk("pri_ready_low", {31'd0, cfg_ready}, 32'd0);
        cyc(); stop_req = 1'b0; tmr_irq = 1'b0; settle();
        chk("pri_ack", {31'd0, tick}, 32'd1);
        chk("pri_ack_ready", {31'd0, cfg_ready}, 32'd0);
        cyc(); settle();
        chk("pri_idle_ready", {31'd0, cfg_ready}, 32'd0);
        chk("pri_count", {16'd0, tick_count}, 32'd7);
        cyc(); settle();
        chk("pri_stp", {11'd0, bus_obs}, {11'd0, b_wr(3'd1, 16'h0008)});
        cyc(); settle();
        chk("pri_stp_clr", {11'd0, bus_obs}, {11'd0, b_wr(3'd0, 16'h0000)});
        cyc(); settle();
        chk("pri_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        cyc(); cfg_valid = 1'b0; settle();
        chk("pri_wr_pl", {11'd0, bus_obs}, {11'd0, b_wr(3'd2, 16'h0002)});

        // ---- reset during WR_PH
        cyc(); settle();
        chk("rmid_wr_ph", {11'd0, bus_obs}, {11'd0, b_wr(3'd3, 16'h0000)});
        reset = 1'b1;
        cyc(); settle();
        chk("rmid_bus", {11'd0, bus_obs}, {11'd0, b_idle()});
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_count", {16'd0, tick_count}, 32'd0);
        chk("rmid_snap", snap_value, 32'd0);
        chk("rmid_ready_in_reset", {31'd0, cfg_ready}, 32'd0);
        reset = 1'b0; settle();
        chk("rmid_ready", {31'd0, cfg_ready}, 32'd1);
        cyc(); settle();
        chk("rmid_stays_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the directed sequence ever stalls
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
